// File: rtl/count_scheduler.sv
// Two-requester round-robin run scheduler: a granted requester's count is loaded
// from its start value and stepped up to TERMINAL, then a one-cycle done pulse is issued.
module count_scheduler #(
    parameter logic [3:0] TERMINAL = 4'b1111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [3:0] start_val0,
    input  logic [3:0] start_val1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic [3:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        COUNT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       ptr_r;
    logic       ptr_nxt_s;
    logic [1:0] gnt_r;
    logic [1:0] gnt_nxt_s;
    logic [1:0] done_r;
    logic [1:0] done_nxt_s;
    logic       busy_r;
    logic       busy_nxt_s;
    logic [3:0] count_r;
    logic [3:0] count_nxt_s;

    logic       sel_s;
    logic       gidx_s;
    logic       req_g_s;
    logic [3:0] start_g_s;
    logic [3:0] count_inc_s;

    // A lone requester wins outright; contention is settled by the pointer.
    function automatic logic pick_requester(input logic [1:0] r, input logic p);
        logic w;
        case (r)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            2'b11:   w = p;
            default: w = p;
        endcase
        return w;
    endfunction

    assign sel_s       = pick_requester(req, ptr_r);
    assign gidx_s      = gnt_r[1];
    assign req_g_s     = |(req & gnt_r);
    assign start_g_s   = gidx_s ? start_val1 : start_val0;
    assign count_inc_s = count_r + 4'd1;

    // Next-state, grant, pointer and count decode.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        count_nxt_s = count_r;
        ptr_nxt_s   = ptr_r;
        done_nxt_s  = 2'b00;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_nxt_s   = sel_s ? 2'b10 : 2'b01;
                    state_nxt_s = LOAD;
                end else begin
                    gnt_nxt_s   = 2'b00;
                end
            end
            LOAD: begin
                if (!req_g_s) begin
                    state_nxt_s = IDLE;
                    gnt_nxt_s   = 2'b00;
                    ptr_nxt_s   = ~gidx_s;
                end else if (start_g_s >= TERMINAL) begin
                    // Clamp so an oversized start value can never push count past TERMINAL.
                    count_nxt_s = TERMINAL;
                    state_nxt_s = DONE;
                    done_nxt_s  = gnt_r;
                end else begin
                    count_nxt_s = start_g_s;
                    state_nxt_s = COUNT;
                end
            end
            COUNT: begin
                if (!req_g_s) begin
                    state_nxt_s = IDLE;
                    gnt_nxt_s   = 2'b00;
                    ptr_nxt_s   = ~gidx_s;
                end else if (count_r >= TERMINAL) begin
                    state_nxt_s = DONE;
                    done_nxt_s  = gnt_r;
                end else if (count_inc_s == TERMINAL) begin
                    count_nxt_s = count_inc_s;
                    state_nxt_s = DONE;
                    done_nxt_s  = gnt_r;
                end else begin
                    count_nxt_s = count_inc_s;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = 2'b00;
                ptr_nxt_s   = ~gidx_s;
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = 2'b00;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State and registered outputs; reset acts without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            ptr_r   <= 1'b0;
            gnt_r   <= 2'b00;
            done_r  <= 2'b00;
            busy_r  <= 1'b0;
            count_r <= 4'b0000;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            gnt_r   <= gnt_nxt_s;
            done_r  <= done_nxt_s;
            busy_r  <= busy_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    assign gnt   = gnt_r;
    assign done  = done_r;
    assign busy  = busy_r;
    assign count = count_r;

endmodule

// File: tb/tb_count_scheduler.sv
// Directed, table-driven bench for count_scheduler with TERMINAL = 15.
module tb_count_scheduler;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [3:0] start_val0;
    logic [3:0] start_val1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] count;

    int tests;
    int fails;

    count_scheduler #(.TERMINAL(4'b1111)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .start_val0(start_val0),
        .start_val1(start_val1),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [3:0] sv0;
        logic [3:0] sv1;
        logic [1:0] gnt;
        logic [1:0] done;
        logic       busy;
        logic [3:0] count;
    } vec_t;

    vec_t vecs[64];
    int   nv;

    task automatic add(input logic r, input logic [1:0] q, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] g, input logic [1:0] d, input logic bz, input logic [3:0] c);
        vecs[nv].rst   = r;
        vecs[nv].req   = q;
        vecs[nv].sv0   = a;
        vecs[nv].sv1   = b;
        vecs[nv].gnt   = g;
        vecs[nv].done  = d;
        vecs[nv].busy  = bz;
        vecs[nv].count = c;
        nv++;
    endtask

    task automatic check_outs(input string name, input logic [1:0] g, input logic [1:0] d,
                              input logic bz, input logic [3:0] c);
        tests++;
        if (gnt !== g || done !== d || busy !== bz || count !== c) begin
            fails++;
            $display("FAIL %s: got gnt=%b done=%b busy=%b count=%0d, want gnt=%b done=%b busy=%b count=%0d",
                     name, gnt, done, busy, count, g, d, bz, c);
        end
        tests++;
        if ($countones(gnt) > 1) begin
            fails++;
            $display("FAIL %s onehot: gnt=%b, want at most one bit", name, gnt);
        end
    endtask

    task automatic cyc(input logic [1:0] q, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        req        = q;
        start_val0 = a;
        start_val1 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        nv         = 0;
        reset      = 1'b1;
        req        = 2'b00;
        start_val0 = 4'd0;
        start_val1 = 4'd0;

        // rst req sv0 sv1 | gnt done busy count
        add(1'b1, 2'b00, 4'd0,  4'd0,  2'b00, 2'b00, 1'b0, 4'd0);
        add(1'b0, 2'b00, 4'd0,  4'd0,  2'b00, 2'b00, 1'b0, 4'd0);
        // lone requester 0 from 12 to 15
        add(1'b0, 2'b01, 4'd12, 4'd0,  2'b01, 2'b00, 1'b1, 4'd0);
        add(1'b0, 2'b01, 4'd12, 4'd0,  2'b01, 2'b00, 1'b1, 4'd12);
        add(1'b0, 2'b01, 4'd0,  4'd9,  2'b01, 2'b00, 1'b1, 4'd13);
        add(1'b0, 2'b11, 4'd0,  4'd9,  2'b01, 2'b00, 1'b1, 4'd14);
        add(1'b0, 2'b01, 4'd0,  4'd0,  2'b01, 2'b01, 1'b1, 4'd15);
        add(1'b0, 2'b00, 4'd0,  4'd0,  2'b00, 2'b00, 1'b0, 4'd15);
        // round robin under continuous contention, from reset
        add(1'b1, 2'b00, 4'd0,  4'd0,  2'b00, 2'b00, 1'b0, 4'd0);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b01, 2'b00, 1'b1, 4'd0);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b01, 2'b00, 1'b1, 4'd13);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b01, 2'b00, 1'b1, 4'd14);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b01, 2'b01, 1'b1, 4'd15);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b00, 2'b00, 1'b0, 4'd15);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b10, 2'b00, 1'b1, 4'd15);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b10, 2'b00, 1'b1, 4'd14);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b10, 2'b10, 1'b1, 4'd15);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b00, 2'b00, 1'b0, 4'd15);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b01, 2'b00, 1'b1, 4'd15);
        add(1'b0, 2'b11, 4'd13, 4'd14, 2'b01, 2'b00, 1'b1, 4'd13);
        add(1'b0, 2'b00, 4'd13, 4'd14, 2'b00, 2'b00, 1'b0, 4'd13);
        // requester 1 starting at TERMINAL: LOAD straight to DONE; req drop in DONE ignored
        add(1'b0, 2'b10, 4'd0,  4'd15, 2'b10, 2'b00, 1'b1, 4'd13);
        add(1'b0, 2'b10, 4'd0,  4'd15, 2'b10, 2'b10, 1'b1, 4'd15);
        add(1'b0, 2'b00, 4'd0,  4'd15, 2'b00, 2'b00, 1'b0, 4'd15);
        // abort in COUNT at 6, then contention goes to requester 1, which aborts in LOAD
        add(1'b0, 2'b01, 4'd3,  4'd0,  2'b01, 2'b00, 1'b1, 4'd15);
        add(1'b0, 2'b01, 4'd3,  4'd0,  2'b01, 2'b00, 1'b1, 4'd3);
        add(1'b0, 2'b01, 4'd3,  4'd0,  2'b01, 2'b00, 1'b1, 4'd4);
        add(1'b0, 2'b01, 4'd3,  4'd0,  2'b01, 2'b00, 1'b1, 4'd5);
        add(1'b0, 2'b01, 4'd3,  4'd0,  2'b01, 2'b00, 1'b1, 4'd6);
        add(1'b0, 2'b00, 4'd3,  4'd0,  2'b00, 2'b00, 1'b0, 4'd6);
        add(1'b0, 2'b11, 4'd3,  4'd2,  2'b10, 2'b00, 1'b1, 4'd6);
        add(1'b0, 2'b01, 4'd3,  4'd2,  2'b00, 2'b00, 1'b0, 4'd6);
        // start 14: 14, 15, then hold at 15
        add(1'b0, 2'b01, 4'd14, 4'd0,  2'b01, 2'b00, 1'b1, 4'd6);
        add(1'b0, 2'b01, 4'd14, 4'd0,  2'b01, 2'b00, 1'b1, 4'd14);
        add(1'b0, 2'b01, 4'd14, 4'd0,  2'b01, 2'b01, 1'b1, 4'd15);
        add(1'b0, 2'b00, 4'd14, 4'd0,  2'b00, 2'b00, 1'b0, 4'd15);
        add(1'b0, 2'b00, 4'd14, 4'd0,  2'b00, 2'b00, 1'b0, 4'd15);

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            req        = vecs[i].req;
            start_val0 = vecs[i].sv0;
            start_val1 = vecs[i].sv1;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].count);
        end

        // Asynchronous reset between edges while counting at 9.
        cyc(2'b01, 4'd7, 4'd0);
        check_outs("ar_grant", 2'b01, 2'b00, 1'b1, 4'd15);
        cyc(2'b01, 4'd7, 4'd0);
        check_outs("ar_load7", 2'b01, 2'b00, 1'b1, 4'd7);
        cyc(2'b01, 4'd7, 4'd0);
        cyc(2'b01, 4'd7, 4'd0);
        check_outs("ar_cnt9", 2'b01, 2'b00, 1'b1, 4'd9);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outs("ar_async", 2'b00, 2'b00, 1'b0, 4'd0);
        #1;
        reset = 1'b0;
        req   = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check_outs($sformatf("ar_after%0d", k), 2'b00, 2'b00, 1'b0, 4'd0);
        end

        // Pointer is back to requester 0 after reset.
        cyc(2'b11, 4'd1, 4'd2);
        check_outs("ar_ptr", 2'b01, 2'b00, 1'b1, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
